// File: rtl/shift_exec_stage_pkg.sv
// Shared constants for the RV64 execute-stage shift unit: opcode encodings
// and operand widths used by the pipeline and its combinational shift core.
package shift_exec_stage_pkg;

    localparam int XLEN    = 64;
    localparam int SHAMT_W = 6;

    localparam logic [1:0] SHIFT_SLL = 2'd0;
    localparam logic [1:0] SHIFT_SRL = 2'd1;
    localparam logic [1:0] SHIFT_SRA = 2'd2;

endpackage

// File: rtl/shift_core.sv
// Combinational 64-bit shifter covering SLL/SRL/SRA and the 32-bit *W forms.
// The caller guarantees shamt < 32 when word is set.
module shift_core
    import shift_exec_stage_pkg::*;
(
    input  logic [XLEN-1:0]    rs1,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [1:0]         op,
    input  logic               word,
    output logic [XLEN-1:0]    result
);

    logic [XLEN-1:0] src;
    logic [XLEN-1:0] shl;
    logic [XLEN-1:0] shr;
    logic [XLEN-1:0] res;
    logic            fill;

    always_comb begin
        fill = (op == SHIFT_SRA) && (word ? rs1[31] : rs1[XLEN-1]);
        // Word ops pre-extend the low half so the 64-bit shifters produce the right low 32 bits.
        src  = word ? {{32{fill}}, rs1[31:0]} : rs1;
        shl  = src << shamt;
        shr  = (src >> shamt) | (~({XLEN{1'b1}} >> shamt) & {XLEN{fill}});
        case (op)
            SHIFT_SLL: res = shl;
            SHIFT_SRL: res = shr;
            SHIFT_SRA: res = shr;
            default:   res = src;
        endcase
        result = word ? {{32{res[31]}}, res[31:0]} : res;
    end

endmodule

// File: rtl/shift_exec_stage.sv
// Two-stage registered shift unit between issue and the mem/wb register:
// S1 captures the micro-op, S2 registers the shifted result for downstream.
module shift_exec_stage #(
    parameter int XLEN = 64,
    parameter int RD_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_op,
    input  logic            in_word,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [5:0]      in_shamt,
    input  logic [RD_W-1:0] in_rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [RD_W-1:0] out_rd
);
    import shift_exec_stage_pkg::*;

    // Handshake: a beat moves on any rising edge where valid && ready; the
    // producer holds valid and payload stable until then, and in_ready is a
    // combinational function of out_ready (no skid buffer).

    logic                s1_valid_q, s1_valid_d;
    logic                s2_valid_q, s2_valid_d;
    logic [1:0]          s1_op_q, s1_op_d;
    logic                s1_word_q;
    logic [XLEN-1:0]     s1_rs1_q;
    logic [SHAMT_W-1:0]  s1_shamt_q, s1_shamt_d;
    logic [RD_W-1:0]     s1_rd_q;
    logic [XLEN-1:0]     out_result_q;
    logic [RD_W-1:0]     out_rd_q;
    logic [XLEN-1:0]     core_result;
    logic                s2_adv, s1_adv, accept, s2_load;

    always_comb begin
        s2_adv     = !s2_valid_q || out_ready;
        s1_adv     = !s1_valid_q || s2_adv;
        in_ready   = s1_adv && !flush;
        accept     = in_valid && in_ready;
        s2_load    = s2_adv && s1_valid_q;
        s1_valid_d = flush ? 1'b0 : (s1_adv ? accept : s1_valid_q);
        s2_valid_d = flush ? 1'b0 : (s2_adv ? s1_valid_q : s2_valid_q);
        // Reserved opcode 3 degrades to an SLL by zero, i.e. a pass-through.
        s1_op_d    = (in_op == 2'd3) ? SHIFT_SLL : in_op;
        if (in_op == 2'd3) begin
            s1_shamt_d = '0;
        end else if (in_word) begin
            s1_shamt_d = {1'b0, in_shamt[4:0]};
        end else begin
            s1_shamt_d = in_shamt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s2_valid_q   <= 1'b0;
            out_result_q <= '0;
            out_rd_q     <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            if (s2_load) begin
                out_result_q <= core_result;
                out_rd_q     <= s1_rd_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            s1_op_q    <= s1_op_d;
            s1_word_q  <= in_word;
            s1_rs1_q   <= in_rs1;
            s1_shamt_q <= s1_shamt_d;
            s1_rd_q    <= in_rd;
        end
    end

    shift_core u_shift_core (
        .rs1    (s1_rs1_q),
        .shamt  (s1_shamt_q),
        .op     (s1_op_q),
        .word   (s1_word_q),
        .result (core_result)
    );

    assign out_valid  = s2_valid_q;
    assign out_result = out_result_q;
    assign out_rd     = out_rd_q;

endmodule

// File: tb/tb_shift_exec_stage.sv
// Self-checking bench for shift_exec_stage: directed and random ops through a
// scoreboard, plus backpressure, flush and asynchronous reset scenarios.
module tb_shift_exec_stage;

    localparam int XLEN = 64;
    localparam int RD_W = 5;
    localparam int EW   = RD_W + XLEN;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [1:0]      in_op = '0;
    logic            in_word = 1'b0;
    logic [XLEN-1:0] in_rs1 = '0;
    logic [5:0]      in_shamt = '0;
    logic [RD_W-1:0] in_rd = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [XLEN-1:0] out_result;
    logic [RD_W-1:0] out_rd;

    shift_exec_stage #(.XLEN(XLEN), .RD_W(RD_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_word    (in_word),
        .in_rs1     (in_rs1),
        .in_shamt   (in_shamt),
        .in_rd      (in_rd),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_rd     (out_rd)
    );

    // ---------------- clock / reset / cycle count ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    // ---------------- scoreboard state ----------------
    logic [EW-1:0] exp_q[$];
    int            acc_q[$];
    int            n_cmp = 0;
    int            n_err = 0;
    bit            chk_lat = 1'b0;
    int            pop_cnt = 0;
    int            first_pop = 0;
    int            last_pop = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Bit-by-bit reference model of the shift semantics.
    function automatic logic [63:0] model(input logic [1:0] op, input logic word,
                                          input logic [63:0] rs1, input logic [5:0] sh);
        logic [63:0] r;
        int n;
        int s;
        r = '0;
        n = word ? 32 : 64;
        s = word ? int'(sh[4:0]) : int'(sh);
        if (op == 2'd3) s = 0;
        for (int i = 0; i < n; i++) begin
            if (op == 2'd1)      r[i] = (i + s < n) ? rs1[i + s] : 1'b0;
            else if (op == 2'd2) r[i] = (i + s < n) ? rs1[i + s] : rs1[n - 1];
            else                 r[i] = (i >= s) ? rs1[i - s] : 1'b0;
        end
        if (word) r[63:32] = {32{r[31]}};
        return r;
    endfunction

    // ---------------- monitor ----------------
    logic [EW-1:0] mon_e;
    int            mon_a;
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", 64'd1, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                mon_a = acc_q.pop_front();
                check("result", out_result, mon_e[XLEN-1:0]);
                check("rd", 64'(out_rd), 64'(mon_e[EW-1:XLEN]));
                if (chk_lat) check("latency", 64'(cyc - mon_a), 64'd2);
                if (pop_cnt == 0) first_pop = cyc;
                last_pop = cyc;
                pop_cnt++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [1:0] op, input logic word, input logic [63:0] rs1,
                        input logic [5:0] sh, input logic [4:0] rd,
                        input logic [63:0] exp, input bit push);
        bit acc;
        in_valid = 1'b1;
        in_op    = op;
        in_word  = word;
        in_rs1   = rs1;
        in_shamt = sh;
        in_rd    = rd;
        acc      = 1'b0;
        for (int i = 0; i < 100 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            if (acc && push) begin
                exp_q.push_back({rd, exp});
                acc_q.push_back(cyc);
            end
        end
        if (!acc) check("accept_timeout", 64'd0, 64'd1);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        check(tag, 64'(exp_q.size()), 64'd0);
    endtask

    // ---------------- directed vectors ----------------
    typedef struct packed {
        logic [1:0]  op;
        logic        word;
        logic [63:0] rs1;
        logic [5:0]  sh;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[10];
    bit   rnd_done;

    initial begin
        vecs[0] = '{op: 2'd0, word: 1'b0, rs1: 64'h1,                 sh: 6'd63, exp: 64'h8000000000000000};
        vecs[1] = '{op: 2'd2, word: 1'b0, rs1: 64'h8000000000000000,  sh: 6'd4,  exp: 64'hF800000000000000};
        vecs[2] = '{op: 2'd1, word: 1'b0, rs1: 64'h8000000000000000,  sh: 6'd4,  exp: 64'h0800000000000000};
        vecs[3] = '{op: 2'd0, word: 1'b1, rs1: 64'h40000000,          sh: 6'd1,  exp: 64'hFFFFFFFF80000000};
        vecs[4] = '{op: 2'd1, word: 1'b1, rs1: 64'hFFFFFFFF80000000,  sh: 6'd31, exp: 64'h1};
        vecs[5] = '{op: 2'd0, word: 1'b1, rs1: 64'h1,                 sh: 6'd33, exp: 64'h2};
        vecs[6] = '{op: 2'd2, word: 1'b1, rs1: 64'h80000000,          sh: 6'd31, exp: 64'hFFFFFFFFFFFFFFFF};
        vecs[7] = '{op: 2'd3, word: 1'b0, rs1: 64'h0123456789ABCDEF,  sh: 6'd17, exp: 64'h0123456789ABCDEF};
        vecs[8] = '{op: 2'd2, word: 1'b0, rs1: 64'h9234567812345678,  sh: 6'd0,  exp: 64'h9234567812345678};
        vecs[9] = '{op: 2'd0, word: 1'b1, rs1: 64'h12345678DEADBEEF,  sh: 6'd0,  exp: 64'hFFFFFFFFDEADBEEF};

        // Reset values while rst_n is low.
        #2;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_result", out_result, 64'd0);
        check("rst_out_rd", 64'(out_rd), 64'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // Directed ops, one at a time, then back-to-back, with latency checks.
        out_ready = 1'b1;
        chk_lat   = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            send(vecs[i].op, vecs[i].word, vecs[i].rs1, vecs[i].sh, 5'(i + 1), vecs[i].exp, 1'b1);
            idle();
            repeat (3) @(posedge clk);
            #1;
        end
        wait_drain("drain_directed");
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++)
            send(vecs[i].op, vecs[i].word, vecs[i].rs1, vecs[i].sh, 5'(i + 11), vecs[i].exp, 1'b1);
        idle();
        wait_drain("drain_stream");

        // Backpressure: four ops against a stalled sink, then release.
        chk_lat   = 1'b0;
        pop_cnt   = 0;
        out_ready = 1'b0;
        @(posedge clk); #1;
        fork
            begin
                for (int i = 0; i < 4; i++)
                    send(vecs[i].op, vecs[i].word, vecs[i].rs1, vecs[i].sh, 5'(i + 21), vecs[i].exp, 1'b1);
                idle();
            end
            begin
                repeat (2) @(posedge clk);
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    check("bp_in_ready", 64'(in_ready), 64'd0);
                    check("bp_out_valid", 64'(out_valid), 64'd1);
                    check("bp_hold_result", out_result, vecs[0].exp);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        wait_drain("drain_bp");
        check("bp_count", 64'(pop_cnt), 64'd4);
        check("bp_back_to_back", 64'(last_pop - first_pop), 64'd3);

        // Random ops with random sink readiness.
        rnd_done = 1'b0;
        @(posedge clk); #1;
        fork
            begin
                for (int i = 0; i < 30; i++) begin
                    logic [1:0]  op;
                    logic        w;
                    logic [63:0] r;
                    logic [5:0]  s;
                    op = 2'($urandom_range(0, 3));
                    w  = 1'($urandom_range(0, 1));
                    r  = {$urandom, $urandom};
                    s  = 6'($urandom_range(0, 63));
                    send(op, w, r, s, 5'($urandom_range(0, 31)), model(op, w, r, s), 1'b1);
                    if ($urandom_range(0, 3) == 0) begin
                        idle();
                        @(posedge clk); #1;
                    end
                end
                idle();
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        wait_drain("drain_random");

        // Flush with an empty pipe: the presented op is refused and dropped.
        @(posedge clk); #1;
        in_valid = 1'b1; in_op = 2'd0; in_rs1 = 64'h55; in_shamt = 6'd1; in_rd = 5'd9;
        flush = 1'b1;
        @(negedge clk);
        check("flush_idle_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        flush = 1'b0; idle();
        @(negedge clk);
        check("flush_idle_after_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("flush_idle_no_out", 64'(out_valid), 64'd0);
        end

        // Flush with two ops in flight plus one presented.
        out_ready = 1'b0;
        @(posedge clk); #1;
        send(2'd0, 1'b0, 64'h1, 6'd1, 5'd1, 64'h2, 1'b0);
        send(2'd1, 1'b0, 64'h4, 6'd1, 5'd2, 64'h2, 1'b0);
        in_rs1 = 64'h8; in_rd = 5'd3;
        flush  = 1'b1;
        @(negedge clk);
        check("flush_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        flush = 1'b0; idle();
        @(negedge clk);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_after_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("flush_no_out", 64'(out_valid), 64'd0);
        end
        chk_lat = 1'b1;
        @(posedge clk); #1;
        send(2'd2, 1'b0, 64'hF000000000000000, 6'd8, 5'd17, 64'hFFF0000000000000, 1'b1);
        idle();
        wait_drain("drain_flush");

        // Asynchronous reset while a result is held under stall.
        chk_lat   = 1'b0;
        out_ready = 1'b0;
        @(posedge clk); #1;
        send(2'd0, 1'b0, 64'h3, 6'd4, 5'd7, 64'h30, 1'b0);
        idle();
        @(posedge clk);
        @(negedge clk);
        check("pre_rst_out_valid", 64'(out_valid), 64'd1);
        check("pre_rst_out_result", out_result, 64'h30);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", 64'(out_valid), 64'd0);
        check("async_rst_out_result", out_result, 64'd0);
        check("async_rst_out_rd", 64'(out_rd), 64'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        check("post_rst_out_valid", 64'(out_valid), 64'd0);
        repeat (3) @(negedge clk);
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/shift_exec_stage.md
Name: shift_exec_stage

Overview:
- Registered execute-stage shift unit for the RV64 core.
- Sits between decode/issue (upstream) and the memory/writeback pipeline register (downstream).
- Accepts a shift micro-op (SLL/SRL/SRA and the RV64 *W variants) over a valid/ready handshake and computes it in a 2-stage pipeline.
- Hands the result plus destination register to the next stage under backpressure and flush.

Parameters:
- XLEN, 64, datapath width; only 64 is supported.
- RD_W, 5, destination register index width.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous kill of all in-flight ops (branch mispredict/trap)
- in_valid  input  1  upstream op valid
- in_ready  output  1  stage can accept an op this cycle
- in_op  input  2  shift opcode: SLL=0, SRL=1, SRA=2; 3 is reserved
- in_word  input  1  1 = *W variant (32-bit shift, sign-extended result)
- in_rs1  input  XLEN  operand to shift
- in_shamt  input  6  shift amount, from rs2[5:0] or the immediate
- in_rd  input  RD_W  destination register
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts the result
- out_result  output  XLEN  shifted value
- out_rd  output  RD_W  destination register

Behaviour:
- Reset (async, rst_n=0): s1_valid=0, s2_valid=0, out_valid=0, out_result=0, out_rd=0. in_ready=1 one cycle after reset is released.
- Transfer rule: a transfer occurs when valid&&ready at a rising edge. Payload is held stable while out_valid&&!out_ready.
- Stage 1 (S1) captures in_op, in_word, in_rs1, in_rd and the masked shamt:
  - !in_word: shamt = in_shamt[5:0].
  - in_word: shamt = {1'b0, in_shamt[4:0]}; bit 5 is ignored.
  - in_op==3 is treated as SLL with shamt 0 (pass-through). It is not an error.
- Stage 2 (S2) registers the shift_core result of S1 into out_result and out_rd.
- Latency: an accepted op appears on out_valid exactly 2 cycles later when no backpressure is applied.
- Throughput: 1 op/cycle.
- Stall rules:
  - s2_adv = !s2_valid || out_ready
  - s1_adv = !s1_valid || s2_adv
  - in_ready = s1_adv; this is combinational from out_ready. No skid buffer.
- Simultaneous accept and drain: an op may enter S1 in the same cycle S2 hands off to downstream and S1 moves to S2.
- Arithmetic:
  - SLL: rs1 << shamt.
  - SRL: logical right shift.
  - SRA: arithmetic right shift on 64 bits.
  - *W: operate on rs1[31:0] only. SRAW sign-fills from bit 31. The 32-bit result is sign-extended from bit 31 to 64 bits, including for SLLW and SRLW.
  - Shamt 0 returns rs1 unchanged (W: sext of rs1[31:0]).
- Flush: at the next edge, s1_valid=0 and s2_valid=0. Data registers are don't-care.
  - An op presented with in_valid in the flush cycle is dropped.
  - in_ready is forced to 0 during flush.
  - The cycle after flush, in_ready=1.
- Reset mid-operation: all in-flight ops are discarded immediately and asynchronously; out_valid drops without waiting for a clock edge.
- Valid bits never depend on data X; payload registers need no reset except the out_* outputs.

Decomposition:
- Shared package holds:
  - op encodings SHIFT_SLL=2'd0, SHIFT_SRL=2'd1, SHIFT_SRA=2'd2;
  - the XLEN constant;
  - the 6-bit shamt width constant.
- One combinational sub-module, shift_core, with inputs (rs1[63:0], shamt[5:0], op[1:0], word) and output result[63:0].
  - It reuses the existing logical-left shifter for SLL and adds right-shift and sign-extend paths.
- The pipeline/handshake logic stays in shift_exec_stage.

Test Plan:
- Basic shifts:
  - SLL rs1=0x1, shamt=63 -> out_result=0x8000000000000000, out_valid exactly 2 cycles after accept, out_rd echoed.
  - SRA rs1=0x8000000000000000, shamt=4 -> 0xF800000000000000.
  - SRL with the same operands -> 0x0800000000000000.
- W variants:
  - SLLW rs1=0x40000000, shamt=1 -> 0xFFFFFFFF80000000.
  - SRLW rs1=0xFFFFFFFF80000000, shamt=31 -> 0x1.
  - SLLW rs1=0x1, shamt=33 -> 0x2 (bit 5 ignored).
  - SRAW rs1=0x80000000, shamt=31 -> 0xFFFFFFFFFFFFFFFF.
- Backpressure:
  - Stream 4 ops with out_ready=0 for 5 cycles -> in_ready drops after 2 accepted, out_result stays stable.
  - Release out_ready -> all 4 results emerge in order, one per cycle, none lost or duplicated.
- Flush: with 2 ops in flight plus in_valid=1, assert flush for 1 cycle -> no out_valid for any of the 3 ops; the next op accepted after flush emerges with 2-cycle latency.
- Reset: assert rst_n=0 asynchronously while out_valid=1 mid-stall -> out_valid=0, out_result=0 before the next clk edge; in_ready=1 after release.
